// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation controller: left-to-right square-and-multiply in the
// Montgomery domain. Each modular product is delegated to an external mon_prod.
// Every product has an issue phase, where mp_start pulses for one cycle, and a
// wait phase, where the controller holds until mp_stop returns.
module mod_exp_ctrl #(
  parameter int unsigned bitLen     = 64,
  parameter int unsigned countWidth = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [bitLen-1:0] X,
  input  logic [bitLen-1:0] E,
  input  logic [bitLen-1:0] M,
  input  logic [bitLen-1:0] Rmod,
  input  logic [bitLen-1:0] R2mod,
  output logic              stop,
  output logic              err,
  output logic [bitLen-1:0] P,
  output logic              mp_start,
  output logic [bitLen-1:0] mp_A,
  output logic [bitLen-1:0] mp_B,
  output logic [bitLen-1:0] mp_M,
  input  logic              mp_stop,
  input  logic [bitLen-1:0] mp_P
);

  typedef enum logic [2:0] {
    StIdle,
    StToMont,
    StSquare,
    StMult,
    StFromMont,
    StDone
  } state_e;

  typedef enum logic {
    PhIssue,
    PhWait
  } phase_e;

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [countWidth-1:0] idx_q, idx_d;
  logic [bitLen-1:0]     x_q, x_d;
  logic [bitLen-1:0]     e_q, e_d;
  logic [bitLen-1:0]     m_q, m_d;
  logic [bitLen-1:0]     r2_q, r2_d;
  logic [bitLen-1:0]     acc_q, acc_d;
  logic [bitLen-1:0]     xbar_q, xbar_d;
  logic [bitLen-1:0]     p_q, p_d;
  logic                  err_q, err_d;

  logic                  in_product;
  logic [bitLen-1:0]     e_shift;
  logic                  e_bit;

  assign in_product = state_q inside {StToMont, StSquare, StMult, StFromMont};

  // Current exponent bit, selected by shifting so the index width may exceed log2(bitLen).
  assign e_shift = e_q >> idx_q;
  assign e_bit   = e_shift[0];

  // State and datapath registers; reset clears everything, aborting any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= PhIssue;
      idx_q   <= '0;
      x_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      r2_q    <= '0;
      acc_q   <= '0;
      xbar_q  <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      e_q     <= e_d;
      m_q     <= m_d;
      r2_q    <= r2_d;
      acc_q   <= acc_d;
      xbar_q  <= xbar_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: operation sequencing and destination-register updates.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    x_d     = x_q;
    e_d     = e_q;
    m_d     = m_q;
    r2_d    = r2_q;
    acc_d   = acc_q;
    xbar_d  = xbar_q;
    p_d     = p_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (M[0]) begin
            x_d     = X;
            e_d     = E;
            m_d     = M;
            r2_d    = R2mod;
            acc_d   = Rmod;  // Montgomery form of 1
            idx_d   = countWidth'(bitLen - 1);
            state_d = StToMont;
            phase_d = PhIssue;
          end else begin
            // Even modulus has no Montgomery inverse: report and skip all products.
            p_d     = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        if (phase_q == PhIssue) begin
          phase_d = PhWait;
        end else if (mp_stop) begin
          phase_d = PhIssue;
          unique case (state_q)
            StToMont: begin
              xbar_d  = mp_P;
              state_d = StSquare;
            end
            StSquare: begin
              acc_d = mp_P;
              if (e_bit) begin
                state_d = StMult;
              end else if (idx_q != '0) begin
                idx_d   = idx_q - countWidth'(1);
                state_d = StSquare;
              end else begin
                state_d = StFromMont;
              end
            end
            StMult: begin
              acc_d = mp_P;
              if (idx_q != '0) begin
                idx_d   = idx_q - countWidth'(1);
                state_d = StSquare;
              end else begin
                state_d = StFromMont;
              end
            end
            StFromMont: begin
              p_d     = mp_P;
              err_d   = 1'b0;
              state_d = StDone;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Product operands; they depend only on registers that change when mp_stop is
  // accepted, so they stay stable across the whole issue and wait phases.
  always_comb begin
    mp_start = 1'b0;
    mp_A     = '0;
    mp_B     = '0;
    unique case (state_q)
      StToMont: begin
        mp_A = x_q;
        mp_B = r2_q;
      end
      StSquare: begin
        mp_A = acc_q;
        mp_B = acc_q;
      end
      StMult: begin
        mp_A = acc_q;
        mp_B = xbar_q;
      end
      StFromMont: begin
        mp_A = acc_q;
        mp_B = bitLen'(1);
      end
      default: ;
    endcase
    if (in_product && (phase_q == PhIssue)) mp_start = 1'b1;
  end

  assign mp_M = m_q;
  assign stop = (state_q == StDone);
  assign err  = err_q;
  assign P    = p_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: a behavioural mon_prod with programmable latency,
// directed cases with known results, and random cases checked against a plain
// modular-exponentiation reference.
module tb_mod_exp_ctrl;

  localparam int BL = 64;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [BL-1:0] X, E, M, Rmod, R2mod;
  logic          stop, err;
  logic [BL-1:0] P;
  logic          mp_start;
  logic [BL-1:0] mp_A, mp_B, mp_M;
  logic          mp_stop = 1'b0;
  logic [BL-1:0] mp_P = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int mp_lat  = 0;
  bit spur_en = 1'b0;
  int stab_errs = 0;

  mod_exp_ctrl #(
    .bitLen    (BL),
    .countWidth(7)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .X       (X),
    .E       (E),
    .M       (M),
    .Rmod    (Rmod),
    .R2mod   (R2mod),
    .stop    (stop),
    .err     (err),
    .P       (P),
    .mp_start(mp_start),
    .mp_A    (mp_A),
    .mp_B    (mp_B),
    .mp_M    (mp_M),
    .mp_stop (mp_stop),
    .mp_P    (mp_P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // a*b*2^-64 mod m, by reducing then halving modulo m 64 times.
  function automatic logic [63:0] mont(input logic [63:0] a, b, m);
    logic [127:0] t;
    t = (128'(a) * 128'(b)) % 128'(m);
    for (int i = 0; i < BL; i++) begin
      if (t[0]) t = t + 128'(m);
      t = t >> 1;
    end
    return t[63:0];
  endfunction

  function automatic logic [63:0] mod_pow(input logic [63:0] x, e, m);
    logic [127:0] r, b;
    r = 128'(1) % 128'(m);
    b = 128'(x) % 128'(m);
    for (int i = 0; i < BL; i++) begin
      if (e[i]) r = (r * b) % 128'(m);
      b = (b * b) % 128'(m);
    end
    return r[63:0];
  endfunction

  function automatic logic [63:0] r_mod(input logic [63:0] m);
    logic [127:0] r;
    r = (128'(1) << BL) % 128'(m);
    return r[63:0];
  endfunction

  function automatic logic [63:0] r2_mod(input logic [63:0] m);
    logic [127:0] r;
    r = 128'(r_mod(m));
    r = (r * r) % 128'(m);
    return r[63:0];
  endfunction

  function automatic int exp_latency(input int pulses, input int lat);
    return pulses * (2 + lat) + 2;
  endfunction

  // Behavioural mon_prod; optionally injects a bogus mp_stop in the issue cycle.
  initial begin
    logic [63:0] cap_a, cap_b, cap_m, res;
    int cnt;
    bit busy, chk;
    busy = 1'b0;
    chk  = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      mp_stop = 1'b0;
      if (!rst_n) chk = 1'b0;
      if (mp_start) begin
        cap_a = mp_A;
        cap_b = mp_B;
        cap_m = mp_M;
        res   = mont(mp_A, mp_B, mp_M);
        cnt   = mp_lat;
        busy  = 1'b1;
        chk   = 1'b1;
        if (spur_en) begin
          mp_stop = 1'b1;
          mp_P    = {$urandom, $urandom};
        end
      end else if (busy) begin
        if (chk && (mp_A !== cap_a || mp_B !== cap_b || mp_M !== cap_m)) stab_errs++;
        if (cnt == 0) begin
          mp_stop = 1'b1;
          mp_P    = res;
          busy    = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic run_op(input string tag, input logic [63:0] x, e, m, input int lat,
                        input bit noise, input logic [63:0] exp_p, input bit exp_err,
                        input int exp_pulses);
    int k, pulses;
    bit seen;
    logic [63:0] got_p;
    logic got_err;
    @(negedge clk);
    X = x; E = e; M = m;
    Rmod  = m[0] ? r_mod(m) : '0;
    R2mod = m[0] ? r2_mod(m) : '0;
    mp_lat = lat;
    spur_en = noise;
    stab_errs = 0;
    start = 1'b1;
    k = 0; pulses = 0; seen = 1'b0; got_p = '0; got_err = 1'b0;
    while (!seen && k < 3000) begin
      @(negedge clk);
      k++;
      start = noise && ($urandom_range(0, 4) == 0);
      if (noise) begin
        X = {$urandom, $urandom}; E = {$urandom, $urandom}; M = {$urandom, $urandom};
        Rmod = {$urandom, $urandom}; R2mod = {$urandom, $urandom};
      end
      if (mp_start) pulses++;
      if (stop) begin
        seen = 1'b1;
        got_p = P;
        got_err = err;
        start = 1'b0;
      end
    end
    spur_en = 1'b0;
    check_eq({tag, "_done"}, 64'(seen), 64'd1);
    check_eq({tag, "_p"}, got_p, exp_p);
    check_eq({tag, "_err"}, 64'(got_err), 64'(exp_err));
    check_eq({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
    check_eq({tag, "_latency"}, 64'(k + 1), 64'(exp_latency(exp_pulses, lat)));
    check_eq({tag, "_stable"}, 64'(stab_errs), 64'd0);
    @(negedge clk);
    check_eq({tag, "_oneshot"}, 64'(stop), 64'd0);
  endtask

  initial begin
    int k, pulses, stray;
    logic [63:0] rx, re, rm;
    int rl, rp;
    rst_n = 1'b1;
    start = 1'b0;
    X = '0; E = '0; M = '0; Rmod = '0; R2mod = '0;
    #1 rst_n = 1'b0;
    #20;
    check_eq("rst_stop", 64'(stop), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_p", P, 64'd0);
    check_eq("rst_mp_start", 64'(mp_start), 64'd0);
    check_eq("rst_mp_a", mp_A, 64'd0);
    check_eq("rst_mp_m", mp_M, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("e2", 64'd216, 64'd2, 64'd311, 1, 1'b0, 64'd6, 1'b0, 67);
    run_op("e3", 64'd216, 64'd3, 64'd311, 0, 1'b0, 64'd52, 1'b0, 68);
    run_op("e0", 64'd216, 64'd0, 64'd311, 3, 1'b0, 64'd1, 1'b0, 66);
    run_op("e1", 64'd216, 64'd1, 64'd311, 2, 1'b0, 64'd216, 1'b0, 67);

    // Abort an E=3 run during the wait phase of its second squaring.
    @(negedge clk);
    X = 64'd216; E = 64'd3; M = 64'd311; Rmod = r_mod(64'd311); R2mod = r2_mod(64'd311);
    mp_lat = 2;
    start = 1'b1;
    k = 0; pulses = 0;
    while (pulses < 3 && k < 1000) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (mp_start) pulses++;
    end
    check_eq("abort_reach", 64'(pulses), 64'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_stop", 64'(stop), 64'd0);
    check_eq("abort_p", P, 64'd0);
    check_eq("abort_mp_start", 64'(mp_start), 64'd0);
    check_eq("abort_mp_b", mp_B, 64'd0);
    check_eq("abort_mp_m", mp_M, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stop || mp_start) stray++;
    end
    check_eq("abort_quiet", 64'(stray), 64'd0);
    run_op("post_rst", 64'd216, 64'd2, 64'd311, 1, 1'b0, 64'd6, 1'b0, 67);

    run_op("even", 64'd216, 64'd3, 64'd310, 1, 1'b0, 64'd0, 1'b1, 0);
    run_op("noise", 64'd216, 64'd3, 64'd311, 1, 1'b1, 64'd52, 1'b0, 68);

    for (int i = 0; i < 8; i++) begin
      rm = {$urandom, $urandom} | 64'h1;
      if (rm == 64'd1) rm = 64'd3;
      rx = {$urandom, $urandom};
      re = (i < 4) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
      rl = $urandom_range(0, 3);
      rp = BL + $countones(re) + 2;
      run_op($sformatf("rnd%0d", i), rx, re, rm, rl, bit'(i % 2), mod_pow(rx, re, rm),
             1'b0, rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
